ucie_ctl_rx_flit_assembler: RTL and testbench

- Sits directly downstream of the RX top; consumes its FDI-side beat stream (data, valid, overflow flag).
- Packs FLIT_BEATS consecutive beats into one flit and hands it to the protocol layer with a valid/ready handshake.
- Drops and counts beats it cannot store, since the upstream stream has no backpressure.
- Reports upstream overflow as a sticky error, gated by the link state request.

---
 rtl/ucie_ctl_rx_pkg.sv | 36 +++
 rtl/ucie_ctl_rx_flit_outreg.sv | 46 ++++
 rtl/ucie_ctl_rx_flit_assembler.sv | 174 +++++++++++++++++
 tb/tb_ucie_ctl_rx_flit_assembler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ucie_ctl_rx_pkg
//  Description : Shared definitions for the UCIe control RX flit assembler.
//                State encodings, default geometry and the beat-counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ucie_ctl_rx_pkg;

    // Assembler state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_ERROR  = 2'd2;

    // Default geometry
    localparam int c_DEF_DATA_W     = 32;
    localparam int c_DEF_FLIT_BEATS = 4;

    // Ceiling log2, valid for values up to 2^31
    function automatic int f_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // The beat counter must also hold FLIT_BEATS, which marks a full assembly
    function automatic int f_beat_cnt_w(input int flit_beats);
        return f_clog2(flit_beats + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucie_ctl_rx_flit_outreg.sv
`default_nettype none
// ============================================================================
//  Module      : ucie_ctl_rx_flit_outreg
//  Description : Flit-wide valid/ready holding register. Loads a new flit
//                when asked, drains on a handshake and holds data stable
//                while the consumer stalls.
//  Ports       : i_clk, i_rst       - clock, synchronous active-high reset
//                i_load, i_load_data - load request and flit to load
//                i_ready             - consumer accepts the held flit
//                o_valid, o_data     - held flit and its qualifier
//  Revision    : 1.0 - initial release
// ============================================================================
module ucie_ctl_rx_flit_outreg #(
    parameter int FLIT_W = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [FLIT_W-1:0] i_load_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [FLIT_W-1:0] o_data
);

    logic              r_valid;
    logic [FLIT_W-1:0] r_data;

    // The parent only asserts i_load when the register is empty or draining,
    // so a load always wins over a drain in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/ucie_ctl_rx_flit_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : ucie_ctl_rx_flit_assembler
//  Description : Packs FLIT_BEATS FDI beats into one flit (beat 0 in the
//                LSBs) and presents it on a valid/ready interface. The
//                assembly register and the output register form a double
//                buffer; beats arriving while both are occupied are dropped
//                and counted. Upstream overflow raises a sticky error.
//  Ports       : i_clk, i_rst           - clock, synchronous active-high reset
//                i_state_request        - 1 = link active, 0 = idle
//                i_fdi_data(_valid)     - beat stream from the RX top
//                i_overflow_detected    - RX top buffer overflow
//                o_flit_data/_valid     - assembled flit, i_flit_ready accepts
//                o_beat_drop            - one-cycle pulse per dropped beat
//                o_drop_count           - saturating dropped-beat count
//                o_error                - overflow error, held while in ERROR
//                o_busy                 - assembly pending or flit held
//  Revision    : 1.0 - initial release
// ============================================================================
module ucie_ctl_rx_flit_assembler
    import ucie_ctl_rx_pkg::*;
#(
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int FLIT_BEATS = c_DEF_FLIT_BEATS,
    parameter int CNT_W      = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_state_request,
    input  logic [DATA_W-1:0]            i_fdi_data,
    input  logic                         i_fdi_data_valid,
    input  logic                         i_overflow_detected,
    output logic [DATA_W*FLIT_BEATS-1:0] o_flit_data,
    output logic                         o_flit_valid,
    input  logic                         i_flit_ready,
    output logic                         o_beat_drop,
    output logic [CNT_W-1:0]             o_drop_count,
    output logic                         o_error,
    output logic                         o_busy
);

    localparam int c_FLIT_W  = DATA_W * FLIT_BEATS;
    localparam int c_BCNT_W  = f_beat_cnt_w(FLIT_BEATS);
    localparam logic [c_BCNT_W-1:0] c_LAST_BEAT = c_BCNT_W'(FLIT_BEATS - 1);
    localparam logic [c_BCNT_W-1:0] c_FULL_CNT  = c_BCNT_W'(FLIT_BEATS);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_BCNT_W-1:0] r_beat_cnt;
    logic                r_full;
    logic [c_FLIT_W-1:0] r_asm;
    logic [c_FLIT_W-1:0] w_asm_nxt;
    logic                r_beat_drop;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic w_active;
    logic w_leave;
    logic w_beat;
    logic w_accept;
    logic w_drop;
    logic w_complete;
    logic w_out_free;
    logic w_load;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_state_request) w_state_nxt = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                // Overflow takes priority over a simultaneous request drop;
                // the error then clears on the following cycle.
                if (i_overflow_detected)   w_state_nxt = c_ST_ERROR;
                else if (!i_state_request) w_state_nxt = c_ST_IDLE;
            end
            c_ST_ERROR: begin
                if (!i_state_request) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat qualification and double-buffer control
    // ------------------------------------------------------------------
    assign w_active   = (r_state == c_ST_ACTIVE);
    // Leaving ACTIVE throws away whatever is in the assembly register
    assign w_leave    = w_active && (i_overflow_detected || !i_state_request);
    // A beat coincident with overflow is neither stored nor counted
    assign w_beat     = w_active && i_fdi_data_valid && !i_overflow_detected;
    assign w_accept   = w_beat && !r_full;
    assign w_drop     = w_beat && r_full;
    assign w_complete = w_accept && (r_beat_cnt == c_LAST_BEAT);
    assign w_out_free = !o_flit_valid || i_flit_ready;
    assign w_load     = (w_complete || r_full) && w_out_free && !w_leave;

    // Next assembly contents include the beat arriving this cycle so that a
    // completing beat can be forwarded to the output register at once.
    generate
        for (genvar k = 0; k < FLIT_BEATS; k++) begin : g_lane
            assign w_asm_nxt[k*DATA_W +: DATA_W] =
                (w_accept && (r_beat_cnt == c_BCNT_W'(k))) ? i_fdi_data
                                                           : r_asm[k*DATA_W +: DATA_W];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_asm      <= '0;
            r_beat_cnt <= '0;
            r_full     <= 1'b0;
        end else begin
            r_asm <= w_asm_nxt;
            if (w_leave) begin
                r_beat_cnt <= '0;
                r_full     <= 1'b0;
            end else if (w_load) begin
                r_beat_cnt <= '0;
                r_full     <= 1'b0;
            end else if (w_complete) begin
                r_beat_cnt <= c_FULL_CNT;
                r_full     <= 1'b1;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop reporting
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat_drop <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_beat_drop <= w_drop;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    ucie_ctl_rx_flit_outreg #(
        .FLIT_W (c_FLIT_W)
    ) u_outreg (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_load_data (w_asm_nxt),
        .i_ready     (i_flit_ready),
        .o_valid     (o_flit_valid),
        .o_data      (o_flit_data)
    );

    assign o_beat_drop  = r_beat_drop;
    assign o_drop_count = r_drop_cnt;
    assign o_error      = (r_state == c_ST_ERROR);
    assign o_busy       = (r_beat_cnt != '0) || r_full || o_flit_valid;

endmodule
`default_nettype wire

// File: tb/tb_ucie_ctl_rx_flit_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ucie_ctl_rx_flit_assembler
//  Description : Self-checking bench for ucie_ctl_rx_flit_assembler. Expected
//                flits are queued when beats are driven and compared when the
//                DUT completes a handshake. A second instance with a 2-bit
//                drop counter exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ucie_ctl_rx_flit_assembler;

    localparam int c_DATA_W = 32;
    localparam int c_BEATS  = 4;
    localparam int c_FLIT_W = c_DATA_W * c_BEATS;

    logic                clk = 1'b0;
    logic                rst;
    logic                state_request;
    logic [c_DATA_W-1:0] fdi_data;
    logic                fdi_data_valid;
    logic                overflow_detected;
    logic                flit_ready;

    logic [c_FLIT_W-1:0] flit_data;
    logic                flit_valid;
    logic                beat_drop;
    logic [7:0]          drop_count;
    logic                error;
    logic                busy;

    logic [c_FLIT_W-1:0] s_flit_data;
    logic                s_flit_valid;
    logic                s_beat_drop;
    logic [1:0]          s_drop_count;
    logic                s_error;
    logic                s_busy;

    int checks = 0;
    int errors = 0;

    logic [c_FLIT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    ucie_ctl_rx_flit_assembler #(
        .DATA_W(c_DATA_W), .FLIT_BEATS(c_BEATS), .CNT_W(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_state_request(state_request),
        .i_fdi_data(fdi_data), .i_fdi_data_valid(fdi_data_valid),
        .i_overflow_detected(overflow_detected),
        .o_flit_data(flit_data), .o_flit_valid(flit_valid),
        .i_flit_ready(flit_ready), .o_beat_drop(beat_drop),
        .o_drop_count(drop_count), .o_error(error), .o_busy(busy)
    );

    ucie_ctl_rx_flit_assembler #(
        .DATA_W(c_DATA_W), .FLIT_BEATS(c_BEATS), .CNT_W(2)
    ) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_state_request(state_request),
        .i_fdi_data(fdi_data), .i_fdi_data_valid(fdi_data_valid),
        .i_overflow_detected(overflow_detected),
        .o_flit_data(s_flit_data), .o_flit_valid(s_flit_valid),
        .i_flit_ready(flit_ready), .o_beat_drop(s_beat_drop),
        .o_drop_count(s_drop_count), .o_error(s_error), .o_busy(s_busy)
    );

    // Scoreboard: every handshake pops one expected flit
    always @(negedge clk) begin
        if (!rst && flit_valid && flit_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL flit_unexpected got=%h expected=none", flit_data);
            end else begin
                logic [c_FLIT_W-1:0] e;
                e = exp_q.pop_front();
                if (flit_data !== e) begin
                    errors++;
                    $display("FAIL flit_data got=%h expected=%h", flit_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [c_FLIT_W-1:0] mk_flit(input logic [31:0] b0, input logic [31:0] b1,
                                                     input logic [31:0] b2, input logic [31:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; state_request = 1'b0; fdi_data = '0; fdi_data_valid = 1'b0;
        overflow_detected = 1'b0; flit_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (flit_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got=%b expected=0", flit_valid); end
        checks++; if (flit_data !== '0)     begin errors++; $display("FAIL rst_data got=%h expected=0", flit_data); end
        checks++; if (beat_drop !== 1'b0)   begin errors++; $display("FAIL rst_drop got=%b expected=0", beat_drop); end
        checks++; if (drop_count !== 8'd0)  begin errors++; $display("FAIL rst_count got=%0d expected=0", drop_count); end
        checks++; if (error !== 1'b0)       begin errors++; $display("FAIL rst_error got=%b expected=0", error); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got=%b expected=0", busy); end
    endtask

    task automatic test_basic();
        logic [31:0] b[4];
        b = '{32'h11, 32'h22, 32'h33, 32'h44};
        flit_ready = 1'b1;
        // Beat in the rising-request cycle is ignored
        state_request = 1'b1; fdi_data_valid = 1'b1; fdi_data = 32'hEE;
        tick();
        exp_q.push_back(mk_flit(b[0], b[1], b[2], b[3]));
        for (int i = 0; i < 4; i++) begin
            fdi_data = b[i];
            tick();
        end
        fdi_data_valid = 1'b0;
        checks++; if (flit_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b expected=1", flit_valid); end
        tick();
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL basic_single got=%b expected=0", flit_valid); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        flit_ready = 1'b0;
        exp_q.push_back(mk_flit(32'h100, 32'h101, 32'h102, 32'h103));
        exp_q.push_back(mk_flit(32'h104, 32'h105, 32'h106, 32'h107));
        fdi_data_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            fdi_data = 32'h100 + i;
            tick();
        end
        fdi_data_valid = 1'b0;
        checks++; if (beat_drop !== 1'b1)  begin errors++; $display("FAIL bp_drop_pulse got=%b expected=1", beat_drop); end
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL bp_drop_count got=%0d expected=1", drop_count); end
        checks++; if (flit_data !== mk_flit(32'h100, 32'h101, 32'h102, 32'h103))
            begin errors++; $display("FAIL bp_hold got=%h expected=%h", flit_data, mk_flit(32'h100, 32'h101, 32'h102, 32'h103)); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL bp_busy got=%b expected=1", busy); end
        tick();
        checks++; if (beat_drop !== 1'b0)  begin errors++; $display("FAIL bp_drop_once got=%b expected=0", beat_drop); end
        flit_ready = 1'b1;
        tick();
        checks++; if (flit_valid !== 1'b1) begin errors++; $display("FAIL b2b_refill got=%b expected=1", flit_valid); end
        tick();
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got=%b expected=0", flit_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL b2b_busy got=%b expected=0", busy); end
        wait_drain();
    endtask

    task automatic test_overflow();
        fdi_data_valid = 1'b1;
        fdi_data = 32'h201; tick();
        fdi_data = 32'h202; tick();
        fdi_data = 32'h203; overflow_detected = 1'b1; tick();
        overflow_detected = 1'b0;
        checks++; if (error !== 1'b1)      begin errors++; $display("FAIL ovf_error got=%b expected=1", error); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL ovf_discard got=%b expected=0", busy); end
        fdi_data = 32'h204; tick();       // ignored in ERROR
        fdi_data_valid = 1'b0;
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_count got=%0d expected=1", drop_count); end
        checks++; if (error !== 1'b1)      begin errors++; $display("FAIL ovf_sticky got=%b expected=1", error); end
        state_request = 1'b0; tick();
        checks++; if (error !== 1'b0)      begin errors++; $display("FAIL ovf_clear got=%b expected=0", error); end
    endtask

    task automatic test_state_drop();
        state_request = 1'b1; tick();
        fdi_data_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            fdi_data = 32'h300 + i;
            tick();
        end
        fdi_data_valid = 1'b0;
        state_request = 1'b0; tick();
        overflow_detected = 1'b1; tick();  // ignored in IDLE
        overflow_detected = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL idle_ovf got=%b expected=0", error); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL idle_discard got=%b expected=0", busy); end
        state_request = 1'b1; tick();
        exp_q.push_back(mk_flit(32'h0A, 32'h0B, 32'h0C, 32'h0D));
        fdi_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fdi_data = 32'h0A + i;
            tick();
        end
        fdi_data_valid = 1'b0;
        wait_drain();
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        test_reset();
        state_request = 1'b1; tick();
        flit_ready = 1'b0;
        exp_q.push_back(mk_flit(32'h400, 32'h401, 32'h402, 32'h403));
        exp_q.push_back(mk_flit(32'h404, 32'h405, 32'h406, 32'h407));
        fdi_data_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            fdi_data = 32'h400 + i;
            tick();
        end
        fdi_data_valid = 1'b0;
        checks++; if (s_drop_count !== 2'd3) begin errors++; $display("FAIL sat_count got=%0d expected=3", s_drop_count); end
        checks++; if (drop_count !== 8'd5)   begin errors++; $display("FAIL wide_count got=%0d expected=5", drop_count); end
        flit_ready = 1'b1;
        wait_drain();
        tick();
    endtask

    task automatic test_reset_mid();
        flit_ready = 1'b0;
        fdi_data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fdi_data = 32'h500 + i;
            tick();
        end
        fdi_data_valid = 1'b0;
        checks++; if (flit_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b expected=1", flit_valid); end
        rst = 1'b1; tick();
        rst = 1'b0;
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b expected=0", flit_valid); end
        checks++; if (flit_data !== '0)    begin errors++; $display("FAIL mid_data got=%h expected=0", flit_data); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_count got=%0d expected=0", drop_count); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL mid_busy got=%b expected=0", busy); end
        flit_ready = 1'b1;
        repeat (6) tick();
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL mid_no_flit got=%b expected=0", flit_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_state_drop();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
